// File: rtl/mem_port_unit.sv
// mem_port_unit: MAR/MDR pair driving a variable-latency memory through a
// read/write handshake on a shared tristate data bus, with an optional wait timeout.
module mem_port_unit #(
    parameter int WIDTH   = 16,
    parameter int AWIDTH  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset_L,
    input  logic [AWIDTH-1:0] addrIn,
    input  logic              loadMAR_L,
    input  logic [WIDTH-1:0]  wrData,
    input  logic              loadMDR_L,
    input  logic              rdReq_L,
    input  logic              wrReq_L,
    input  logic              memAck,
    output logic [AWIDTH-1:0] memAddr,
    output logic [WIDTH-1:0]  MDRout,
    inout  wire  [WIDTH-1:0]  dataBus,
    output logic              memRe_L,
    output logic              memWe_L,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    state_t state, state_nx;
    logic [7:0] cnt;
    logic expire, ld_ok;
    assign busy    = state == RD || state == WR;
    assign done    = state == DONE;
    assign ld_ok   = state == IDLE || state == DONE;
    assign dataBus = state == WR ? MDRout : 'z;
    // an ack arriving on the last allowed edge beats the timeout
    assign expire  = TIMEOUT != 0 && !memAck && cnt == 8'(TIMEOUT - 1);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !rdReq_L ? RD : !wrReq_L ? WR : IDLE;
            RD, WR:  state_nx = memAck || expire ? DONE : state;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state   <= IDLE;
            memAddr <= '0;
            MDRout  <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            memRe_L <= 1'b1;
            memWe_L <= 1'b1;
        end else begin
            state   <= state_nx;
            memRe_L <= state_nx != RD;
            memWe_L <= state_nx != WR;
            if (ld_ok && !loadMAR_L) memAddr <= addrIn;
            if (ld_ok && !loadMDR_L) MDRout <= wrData;
            else if (state == RD && memAck) MDRout <= dataBus;
            if (state == IDLE && state_nx != IDLE) begin
                cnt <= '0;
                err <= 1'b0;
            end else if (busy && !memAck) begin
                cnt <= cnt + 8'd1;
                if (expire) err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_unit.sv
// tb_mem_port_unit: scoreboarded bench for mem_port_unit at 16-bit and 32/24-bit widths.
module tb_mem_port_unit;
    logic clock = 1'b0, reset_L = 1'b0;
    logic [15:0] addrIn = '0, wrData = '0, mem_drv = '0;
    logic loadMAR_L = 1'b1, loadMDR_L = 1'b1, rdReq_L = 1'b1, wrReq_L = 1'b1, memAck = 1'b0, mem_oe = 1'b0;
    wire  [15:0] dataBus;
    logic [15:0] memAddr, MDRout;
    logic memRe_L, memWe_L, busy, done, err;
    assign dataBus = mem_oe ? mem_drv : 'z;

    logic [23:0] addr_w = '0;
    logic [31:0] wdata_w = '0, drv_w = '0;
    logic ldmar_w = 1'b1, ldmdr_w = 1'b1, rd_w = 1'b1, wr_w = 1'b1, ack_w = 1'b0, oe_w = 1'b0;
    wire  [31:0] bus_w;
    logic [23:0] maddr_w;
    logic [31:0] mdr_w;
    logic re_w, we_w, busy_w, done_w, err_w;
    assign bus_w = oe_w ? drv_w : 'z;

    mem_port_unit u0 (
        .clock(clock), .reset_L(reset_L), .addrIn(addrIn), .loadMAR_L(loadMAR_L),
        .wrData(wrData), .loadMDR_L(loadMDR_L), .rdReq_L(rdReq_L), .wrReq_L(wrReq_L),
        .memAck(memAck), .memAddr(memAddr), .MDRout(MDRout), .dataBus(dataBus),
        .memRe_L(memRe_L), .memWe_L(memWe_L), .busy(busy), .done(done), .err(err)
    );
    mem_port_unit #(.WIDTH(32), .AWIDTH(24), .TIMEOUT(15)) u1 (
        .clock(clock), .reset_L(reset_L), .addrIn(addr_w), .loadMAR_L(ldmar_w),
        .wrData(wdata_w), .loadMDR_L(ldmdr_w), .rdReq_L(rd_w), .wrReq_L(wr_w),
        .memAck(ack_w), .memAddr(maddr_w), .MDRout(mdr_w), .dataBus(bus_w),
        .memRe_L(re_w), .memWe_L(we_w), .busy(busy_w), .done(done_w), .err(err_w)
    );

    typedef struct { logic [31:0] mdr; logic err; } exp_t;
    exp_t sb[$];
    int n_vec = 0, n_bad = 0;
    logic [15:0] m_mdr = '0;

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] d);
        addrIn = a; wrData = d; loadMAR_L = 1'b0; loadMDR_L = 1'b0;
        @(negedge clock);
        loadMAR_L = 1'b1; loadMDR_L = 1'b1; m_mdr = d;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] mdr, input logic e_flag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_mdr"}, mdr, e.mdr);
            check({tag, "_err"}, {31'd0, e_flag}, {31'd0, e.err});
        end
    endtask

    // waits: ack on edge waits+1 of the busy phase; large waits means never ack
    task automatic xfer(input string tag, input bit rd, input bit wr, input int waits,
                        input logic [15:0] rdata, input bit spoil, input bit hold);
        int cyc = 0, t = 0;
        bit tmo = waits + 1 > 15;
        exp_t e;
        e.mdr = rd && !tmo ? {16'd0, rdata} : {16'd0, m_mdr};
        e.err = tmo;
        sb.push_back(e);
        rdReq_L = !rd; wrReq_L = !wr;
        @(negedge clock);
        rdReq_L = !hold; wrReq_L = 1'b1;
        while (!done && t < 40) begin
            if (busy) begin
                cyc++;
                check({tag, "_strobe"}, {30'd0, memRe_L, memWe_L}, rd ? 32'd1 : 32'd2);
                if (!rd) check({tag, "_bus"}, {16'd0, dataBus}, {16'd0, m_mdr});
                memAck = cyc == waits + 1;
                mem_oe = rd;
                mem_drv = memAck ? rdata : ~rdata;
                if (spoil) begin loadMDR_L = 1'b0; wrData = 16'hAAAA; end
            end
            @(negedge clock); t++;
        end
        memAck = 1'b0; mem_oe = 1'b0; loadMDR_L = 1'b1;
        m_mdr = e.mdr[15:0];
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_cycles"}, cyc, tmo ? 15 : waits + 1);
        check({tag, "_done_st"}, {29'd0, memRe_L, memWe_L, busy}, 32'd6);
        pop_check(tag, {16'd0, MDRout}, err);
        @(negedge clock);
        check({tag, "_idle"}, {29'd0, busy, done, err}, {31'd0, e.err});
    endtask

    initial begin
        @(negedge clock);
        check("rst_out", {11'd0, memRe_L, memWe_L, busy, done, err, memAddr}, {11'd0, 5'b11000, 16'h0});
        check("rst_mdr", {16'd0, MDRout}, 32'd0);
        reset_L = 1'b1;
        @(negedge clock);
        load(16'h0022, 16'h1111);
        wrReq_L = 1'b0;
        @(negedge clock);
        wrReq_L = 1'b1;
        @(negedge clock);
        check("midwr_we", {31'd0, memWe_L}, 32'd0);
        check("midwr_bus", {16'd0, dataBus}, 32'h1111);
        #2 reset_L = 1'b0;
        #1 check("async_rst", {13'd0, memWe_L, busy, memAddr, MDRout[0]}, {13'd0, 2'b10, 17'd0});
        check("async_mdr", {16'd0, MDRout}, 32'd0);
        @(negedge clock);
        reset_L = 1'b1; m_mdr = '0;
        @(negedge clock);
        check("rel_busy", {31'd0, busy}, 32'd0);

        load(16'h0040, 16'h0000);
        check("mar", {16'd0, memAddr}, 32'h0040);
        xfer("rd0", 1, 0, 0, 16'hBEEF, 0, 0);
        load(16'h0040, 16'h1234);
        xfer("wr3", 0, 1, 3, 16'h0, 0, 0);
        xfer("tmo", 1, 0, 99, 16'h5555, 0, 0);
        xfer("rd_clr", 1, 0, 1, 16'h7E57, 0, 0);
        xfer("last_ack", 1, 0, 14, 16'hC0DE, 0, 0);
        xfer("both", 1, 1, 2, 16'h3C3C, 0, 0);
        xfer("spoil", 1, 0, 2, 16'h9876, 1, 0);
        xfer("hold", 1, 0, 0, 16'h4242, 0, 1);
        xfer("hold2", 1, 0, 0, 16'h2424, 0, 0);

        addr_w = 24'hABCDEF; wdata_w = 32'hDEADBEEF;
        ldmar_w = 1'b0; ldmdr_w = 1'b0; wr_w = 1'b0;
        sb.push_back('{32'hDEADBEEF, 1'b0});
        @(negedge clock);
        ldmar_w = 1'b1; ldmdr_w = 1'b1; wr_w = 1'b1;
        check("w32_we", {30'd0, re_w, we_w}, 32'd2);
        check("w32_bus", bus_w, 32'hDEADBEEF);
        check("w32_addr", {8'd0, maddr_w}, 32'h00ABCDEF);
        ack_w = 1'b1;
        @(negedge clock);
        ack_w = 1'b0;
        check("w32_done", {31'd0, done_w}, 32'd1);
        pop_check("w32", mdr_w, err_w);
        @(negedge clock);
        wdata_w = '0; ldmdr_w = 1'b0;
        @(negedge clock);
        ldmdr_w = 1'b1;
        check("w32_clr", mdr_w, 32'd0);
        rd_w = 1'b0;
        sb.push_back('{32'hDEADBEEF, 1'b0});
        @(negedge clock);
        rd_w = 1'b1;
        check("r32_re", {30'd0, re_w, we_w}, 32'd1);
        ack_w = 1'b1; oe_w = 1'b1; drv_w = 32'hDEADBEEF;
        @(negedge clock);
        ack_w = 1'b0; oe_w = 1'b0;
        check("r32_done", {31'd0, done_w}, 32'd1);
        pop_check("r32", mdr_w, err_w);
        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
